ofifo: RTL and testbench

Output FIFO bank at the south edge of the weight-stationary systolic array. It captures the `psum_bw`-wide partial sums leaving the bottom `mac_tile` row, with one independent FIFO per column, because columns finish on staggered cycles. It presents them to the SFU/accumulation stage as one aligned `col`-wide word once every column holds data.

---
 rtl/ofifo_pkg.sv | 19 +
 rtl/ofifo_fifo_col.sv | 68 ++++++
 rtl/ofifo.sv | 73 +++++++
 tb/tb_ofifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ofifo_pkg.sv
// rtl/ofifo_pkg.sv - shared sizing constants for the array edge FIFOs
//
// Holds the default array geometry and the pointer-width helper that both
// the south-edge output FIFO and the L0 input FIFO size their pointers with.
// Pointers carry one bit beyond the address so full and empty are distinct.

package ofifo_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 64;

  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int PTR_W = ptr_width(DEPTH);

endpackage

// File: rtl/ofifo_fifo_col.sv
// rtl/ofifo_fifo_col.sv - single-column psum FIFO with registered head output
//
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous, active-high; clears pointers and out
//   wr     push in when not full (full is sampled pre-edge)
//   rd     pop head into out when not empty; caller gates row alignment
//   in     word to push
//   out    last popped word, held until the next pop
//   full   combinational from pointers
//   empty  combinational from pointers

module fifo_col
  import ofifo_pkg::*;
#(
  parameter int width = PSUM_BW,
  parameter int depth = DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] in,
  output logic [width-1:0] out,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer MSB tells a wrapped (full) FIFO from an empty one.
  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Storage has no reset; writes in the reset cycle are suppressed instead.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      mem[wp[AW-1:0]] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      out <= '0;
    end else begin
      if (do_wr) begin
        wp <= wp + PW'(1);
      end
      if (do_rd) begin
        out <= mem[rp[AW-1:0]];
        rp  <= rp + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ofifo.sv
// rtl/ofifo.sv - south-edge output FIFO bank, one FIFO per array column
//
// Captures staggered per-column partial sums and releases them as one
// aligned row once every column holds data.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset       synchronous, active-high
//   in          column psums, column i at [i*psum_bw +: psum_bw]
//   wr          per-column write strobe
//   rd          pop one aligned row (ignored unless o_valid)
//   out         registered popped row, same packing as in
//   o_valid     every column non-empty
//   o_full      any column full
//   o_ready     !o_full
//   o_overflow  sticky: a write hit a full column

module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  logic [col-1:0] full_vec;
  logic [col-1:0] empty_vec;
  logic           rd_accept;

  // Flags derive from pointer registers only, so there is no path from
  // wr/rd/in to any output.
  assign o_valid   = &(~empty_vec);
  assign o_full    = |full_vec;
  assign o_ready   = !o_full;
  // A pop moves every column together, so it needs all of them non-empty.
  assign rd_accept = rd && o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    fifo_col #(
      .width (psum_bw),
      .depth (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .rd    (rd_accept),
      .in    (in[i*psum_bw +: psum_bw]),
      .out   (out[i*psum_bw +: psum_bw]),
      .full  (full_vec[i]),
      .empty (empty_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (|(wr & full_vec)) begin
      o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo.sv
// tb/tb_ofifo.sv - directed vector bench for the ofifo output FIFO bank

module tb_ofifo;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out;
  logic         o_valid;
  logic         o_full;
  logic         o_ready;
  logic         o_overflow;

  int n_vec = 0;
  int n_err = 0;

  ofifo #(.col(8), .psum_bw(16), .depth(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [7:0]   wr;
    logic         rd;
    logic [127:0] din;
    logic [127:0] eout;
    logic         ev;
    logic         ef;
    logic         eo;
  } vec_t;

  vec_t tbl [20];

  // Row whose column i holds base + i*step.
  function automatic logic [127:0] row(input int base, input int step);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(base + i*step);
    return r;
  endfunction

  function automatic vec_t mk(input logic rs, input logic [7:0] w, input logic r,
                              input logic [127:0] d, input logic [127:0] eo_,
                              input logic v, input logic f, input logic o);
    vec_t t;
    t.rst = rs; t.wr = w; t.rd = r; t.din = d;
    t.eout = eo_; t.ev = v; t.ef = f; t.eo = o;
    return t;
  endfunction

  task automatic step(input logic rs, input logic [7:0] w, input logic r,
                      input logic [127:0] d);
    reset = rs; wr = w; rd = r; in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic v, input logic f, input logic o);
    chk({name, ".flags"}, {124'd0, o_valid, o_full, o_ready, o_overflow},
        {124'd0, v, f, !f, o});
  endtask

  initial begin
    logic [127:0] held;
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;

    // reset and idle
    tbl[0] = mk(1, 8'h00, 0, '0, '0, 0, 0, 0);
    tbl[1] = mk(0, 8'h00, 0, '0, '0, 0, 0, 0);
    tbl[2] = mk(0, 8'h00, 0, '0, '0, 0, 0, 0);
    tbl[3] = mk(0, 8'h00, 0, '0, '0, 0, 0, 0);
    // staggered fill: column i writes 0x100+i on its own cycle
    for (int i = 0; i < 8; i++)
      tbl[4+i] = mk(0, 8'(1 << i), 0, row(16'h100, 1), '0, (i == 7), 0, 0);
    tbl[12] = mk(0, 8'h00, 1, '0, row(16'h100, 1), 0, 0, 0);
    // pop while empty is ignored
    tbl[13] = mk(0, 8'h00, 1, '0, row(16'h100, 1), 0, 0, 0);
    // column 3 never written: rd ignored, out held
    tbl[14] = mk(0, 8'hF7, 0, row(16'h200, 1), row(16'h100, 1), 0, 0, 0);
    tbl[15] = mk(0, 8'h00, 1, '0, row(16'h100, 1), 0, 0, 0);
    tbl[16] = mk(1, 8'h00, 0, '0, '0, 0, 0, 0);
    // same-cycle write and read keeps occupancy
    tbl[17] = mk(0, 8'hFF, 0, row(16'h300, 1), '0, 1, 0, 0);
    tbl[18] = mk(0, 8'hFF, 1, row(16'h400, 1), row(16'h300, 1), 1, 0, 0);
    tbl[19] = mk(0, 8'h00, 1, '0, row(16'h400, 1), 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      step(tbl[k].rst, tbl[k].wr, tbl[k].rd, tbl[k].din);
      chk($sformatf("vec%0d", k),
          {out, o_valid, o_full, o_ready, o_overflow},
          {tbl[k].eout, tbl[k].ev, tbl[k].ef, !tbl[k].ef, tbl[k].eo});
    end

    // fill to full, overflow, drain in order
    step(1, 8'h00, 0, '0);
    for (int k = 0; k < 64; k++) begin
      step(0, 8'hFF, 0, row(k, 0));
      if (k == 62) chk_flags("fill63", 1, 0, 0);
    end
    chk_flags("full64", 1, 1, 0);
    step(0, 8'h01, 0, row(16'hDEAD, 0));
    chk_flags("overflow", 1, 1, 1);
    for (int k = 0; k < 64; k++) begin
      step(0, 8'h00, 1, '0);
      chk($sformatf("drain%0d", k), out, row(k, 0));
    end
    chk_flags("drained", 0, 0, 1);
    step(0, 8'h00, 1, '0);
    chk("no_extra", out, row(63, 0));

    // full column with same-cycle accepted read still drops the write
    step(1, 8'h00, 0, '0);
    for (int k = 0; k < 64; k++) step(0, 8'hFF, 0, row(k + 1000, 0));
    step(0, 8'h01, 1, row(16'hBEEF, 0));
    chk("full_rd_out", out, row(1000, 0));
    chk_flags("full_rd_flags", 1, 0, 1);

    // wrap-around streaming after a 1-deep prefill
    step(1, 8'h00, 0, '0);
    step(0, 8'hFF, 0, row(0, 1));
    for (int k = 0; k < 200; k++) begin
      step(0, 8'hFF, 1, row(k + 1, 1));
      chk($sformatf("stream%0d", k), {out, o_valid, o_full, o_overflow},
          {row(k, 1), 1'b1, 1'b0, 1'b0});
    end

    // reset mid-stream with 10 rows queued
    step(1, 8'h00, 0, '0);
    for (int k = 0; k < 10; k++) step(0, 8'hFF, 0, row(16'h700 + k, 0));
    step(0, 8'h00, 1, '0);
    held = out;
    chk("pre_reset_out", held, row(16'h700, 0));
    step(1, 8'hFF, 1, row(16'h7FF, 0));
    chk("mid_reset_out", out, '0);
    chk_flags("mid_reset_flags", 0, 0, 0);
    step(0, 8'hFF, 0, row(16'h55, 1));
    chk_flags("post_reset_wr", 1, 0, 0);
    step(0, 8'h00, 1, '0);
    chk("post_reset_rd", out, row(16'h55, 1));
    chk_flags("post_reset_empty", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
